// File: rtl/forwarding_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : forwarding_unit_if
// Brief    : Operand-bypass bundle between EX-stage hazard logic and the
//            forwarding selector: register indices and write enables in,
//            mux selects and event counters out.
// Revision : 1.0 - initial release
// ============================================================================
interface forwarding_unit_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1_ex;
    logic [4:0]       rs2_ex;
    logic [4:0]       rd_me;
    logic             RUWr_me;
    logic [4:0]       rd_wb;
    logic             RUWr_wb;
    logic             cnt_clr;
    logic [1:0]       FUASrc;
    logic [1:0]       FUBSrc;
    logic [CNT_W-1:0] fwd_me_cnt;
    logic [CNT_W-1:0] fwd_wb_cnt;

    modport master (
        output rs1_ex, rs2_ex, rd_me, RUWr_me, rd_wb, RUWr_wb, cnt_clr,
        input  FUASrc, FUBSrc, fwd_me_cnt, fwd_wb_cnt
    );

    modport slave (
        input  rs1_ex, rs2_ex, rd_me, RUWr_me, rd_wb, RUWr_wb, cnt_clr,
        output FUASrc, FUBSrc, fwd_me_cnt, fwd_wb_cnt
    );
endinterface
`default_nettype wire

// File: rtl/forwarding_unit.sv
`default_nettype none
// ============================================================================
// Module   : forwarding_unit
// Brief    : EX-stage ALU operand bypass selector with saturating counters
//            of MEM- and WB-sourced forwarding events.
// Revision : 1.0 - initial release
// ============================================================================
module forwarding_unit #(
    parameter int CNT_W = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    forwarding_unit_if.slave  fu
);
    localparam logic [1:0] c_SEL_RF = 2'b00;
    localparam logic [1:0] c_SEL_ME = 2'b01;
    localparam logic [1:0] c_SEL_WB = 2'b10;

    // MEM is checked first: it holds the younger result; x0 is never bypassed.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_me,
        input logic       we_me,
        input logic [4:0] rd_wb,
        input logic       we_wb
    );
        logic [1:0] sel;
        sel = c_SEL_RF;
        if (we_me && (rd_me != 5'd0) && (rd_me == rs)) begin
            sel = c_SEL_ME;
        end else if (we_wb && (rd_wb != 5'd0) && (rd_wb == rs)) begin
            sel = c_SEL_WB;
        end
        return sel;
    endfunction

    logic [1:0]       w_a_sel;
    logic [1:0]       w_b_sel;
    logic [1:0]       w_me_inc;
    logic [1:0]       w_wb_inc;
    logic [CNT_W:0]   w_me_sum;
    logic [CNT_W:0]   w_wb_sum;
    logic [CNT_W-1:0] w_me_next;
    logic [CNT_W-1:0] w_wb_next;
    logic [CNT_W-1:0] r_me_cnt;
    logic [CNT_W-1:0] r_wb_cnt;

    always_comb begin
        w_a_sel = fwd_sel(fu.rs1_ex, fu.rd_me, fu.RUWr_me, fu.rd_wb, fu.RUWr_wb);
        w_b_sel = fwd_sel(fu.rs2_ex, fu.rd_me, fu.RUWr_me, fu.rd_wb, fu.RUWr_wb);
    end

    assign w_me_inc = {1'b0, (w_a_sel == c_SEL_ME)} + {1'b0, (w_b_sel == c_SEL_ME)};
    assign w_wb_inc = {1'b0, (w_a_sel == c_SEL_WB)} + {1'b0, (w_b_sel == c_SEL_WB)};

    // One extra sum bit catches overflow so the counters clamp instead of wrapping.
    assign w_me_sum  = {1'b0, r_me_cnt} + {{(CNT_W-1){1'b0}}, w_me_inc};
    assign w_wb_sum  = {1'b0, r_wb_cnt} + {{(CNT_W-1){1'b0}}, w_wb_inc};
    assign w_me_next = w_me_sum[CNT_W] ? {CNT_W{1'b1}} : w_me_sum[CNT_W-1:0];
    assign w_wb_next = w_wb_sum[CNT_W] ? {CNT_W{1'b1}} : w_wb_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst || fu.cnt_clr) begin
            r_me_cnt <= '0;
            r_wb_cnt <= '0;
        end else begin
            r_me_cnt <= w_me_next;
            r_wb_cnt <= w_wb_next;
        end
    end

    assign fu.FUASrc     = w_a_sel;
    assign fu.FUBSrc     = w_b_sel;
    assign fu.fwd_me_cnt = r_me_cnt;
    assign fu.fwd_wb_cnt = r_wb_cnt;
endmodule
`default_nettype wire

// File: tb/tb_forwarding_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_forwarding_unit
// Brief    : Directed and random checks of forwarding_unit at CNT_W=32 and 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_forwarding_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    longint m_me32 = 0, m_wb32 = 0, m_me4 = 0, m_wb4 = 0;

    forwarding_unit_if #(.CNT_W(32)) if32 ();
    forwarding_unit_if #(.CNT_W(4))  if4 ();

    forwarding_unit #(.CNT_W(32)) u_dut32 (.clk(clk), .rst(rst), .fu(if32.slave));
    forwarding_unit #(.CNT_W(4))  u_dut4  (.clk(clk), .rst(rst), .fu(if4.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_sel(input int rs, input int dm, input bit wm,
                                           input int dw, input bit ww);
        if (wm && dm != 0 && dm == rs) return 2'b01;
        if (ww && dw != 0 && dw == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic longint sat_add(input longint cur, input int inc, input longint maxv);
        return (cur + inc > maxv) ? maxv : cur + inc;
    endfunction

    // One cycle: apply inputs, check selects, cross the edge, check counters.
    task automatic step(input int a, input int b, input int dm, input bit wm,
                        input int dw, input bit ww, input bit clr, input bit r);
        logic [1:0] ea, eb;
        int inc_me, inc_wb;
        if32.rs1_ex = 5'(a); if32.rs2_ex = 5'(b); if32.rd_me = 5'(dm);
        if32.RUWr_me = wm;   if32.rd_wb = 5'(dw);  if32.RUWr_wb = ww; if32.cnt_clr = clr;
        if4.rs1_ex  = 5'(a); if4.rs2_ex  = 5'(b); if4.rd_me  = 5'(dm);
        if4.RUWr_me = wm;    if4.rd_wb  = 5'(dw);  if4.RUWr_wb  = ww; if4.cnt_clr  = clr;
        rst = r;
        #1;
        ea = exp_sel(a, dm, wm, dw, ww);
        eb = exp_sel(b, dm, wm, dw, ww);
        chk("FUASrc",    64'(if32.FUASrc), 64'(ea));
        chk("FUBSrc",    64'(if32.FUBSrc), 64'(eb));
        chk("FUASrc_w4", 64'(if4.FUASrc),  64'(ea));
        chk("FUBSrc_w4", 64'(if4.FUBSrc),  64'(eb));
        inc_me = int'(ea == 2'b01) + int'(eb == 2'b01);
        inc_wb = int'(ea == 2'b10) + int'(eb == 2'b10);
        @(posedge clk);
        if (r || clr) begin
            m_me32 = 0; m_wb32 = 0; m_me4 = 0; m_wb4 = 0;
        end else begin
            m_me32 = sat_add(m_me32, inc_me, 64'hFFFF_FFFF);
            m_wb32 = sat_add(m_wb32, inc_wb, 64'hFFFF_FFFF);
            m_me4  = sat_add(m_me4,  inc_me, 15);
            m_wb4  = sat_add(m_wb4,  inc_wb, 15);
        end
        #1;
        chk("me_cnt32", 64'(if32.fwd_me_cnt), 64'(m_me32));
        chk("wb_cnt32", 64'(if32.fwd_wb_cnt), 64'(m_wb32));
        chk("me_cnt4",  64'(if4.fwd_me_cnt),  64'(m_me4));
        chk("wb_cnt4",  64'(if4.fwd_wb_cnt),  64'(m_wb4));
    endtask

    initial begin
        @(posedge clk); #1;
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("reset_me", 64'(if32.fwd_me_cnt), 64'd0);
        chk("reset_wb", 64'(if32.fwd_wb_cnt), 64'd0);

        step(8, 10, 8, 1, 0, 1, 0, 0);
        step(2, 8, 8, 1, 0, 0, 0, 0);
        step(4, 5, 0, 1, 4, 1, 0, 0);
        step(4, 3, 0, 0, 3, 1, 0, 0);
        step(6, 6, 6, 1, 6, 1, 0, 0);
        step(6, 6, 6, 0, 6, 1, 0, 0);
        step(5, 6, 7, 0, 8, 0, 0, 0);
        step(0, 9, 0, 1, 0, 0, 0, 0);

        // reset with live forwarding: nothing counted
        step(6, 6, 6, 1, 6, 1, 0, 1);
        chk("rst_mid_me", 64'(if32.fwd_me_cnt), 64'd0);
        for (int i = 0; i < 3; i++) step(6, 6, 6, 1, 6, 1, 0, 0);
        chk("dbl_me_6", 64'(if32.fwd_me_cnt), 64'd6);
        chk("dbl_me_wb0", 64'(if32.fwd_wb_cnt), 64'd0);
        step(6, 6, 6, 1, 6, 1, 1, 0);
        chk("clr_me", 64'(if32.fwd_me_cnt), 64'd0);

        for (int i = 0; i < 10; i++) step(6, 6, 6, 0, 6, 1, 0, 0);
        chk("sat_wb4", 64'(if4.fwd_wb_cnt), 64'd15);
        chk("wb32_20", 64'(if32.fwd_wb_cnt), 64'd20);
        step(6, 6, 6, 0, 6, 1, 1, 1);
        chk("rst_clr_wb4", 64'(if4.fwd_wb_cnt), 64'd0);

        for (int i = 0; i < 300; i++) begin
            step(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
